// File: rtl/pc_fetch_gen_pkg.sv
// Shared constants and helpers for the IF-stage PC generator.
package pc_fetch_gen_pkg;

    // Default address width and the PC held while fetch is disabled.
    localparam int unsigned  ADDR_W_DEF       = 32;
    localparam logic [31:0]  RESET_VECTOR_DEF = 32'h3000_0000;

    // Legacy control-level names used by ctrl/id.
    localparam logic CHIP_ENABLE  = 1'b1;
    localparam logic CHIP_DISABLE = 1'b0;
    localparam logic STOP         = 1'b1;
    localparam logic BRANCH       = 1'b1;

    // Source of the next PC, resolved once per cycle in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD   = 3'd0,
        SEL_FLUSH  = 3'd1,
        SEL_BRANCH = 3'd2,
        SEL_PEND   = 3'd3,
        SEL_STEP   = 3'd4
    } pc_sel_e;

    // True when an address is not a whole number of instructions.
    function automatic logic addr_misaligned(input logic [63:0] addr,
                                             input int unsigned inst_bytes);
        logic [63:0] mask;
        mask = 64'(inst_bytes) - 64'd1;
        return (addr & mask) != 64'd0;
    endfunction

endpackage

// File: rtl/pc_fetch_gen_redirect_hold.sv
// Holds a branch redirect that arrived while fetch could not advance.
module pc_fetch_gen_redirect_hold #(
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              flush_i,
    input  logic              adv_i,
    input  logic              branch_i,
    input  logic [ADDR_W-1:0] target_i,
    output logic              pend_o,
    output logic [ADDR_W-1:0] pend_addr_o
);

    logic              pend_q, pend_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    // A flush or any advance consumes/discards the held target; a stalled branch (re)loads it.
    always_comb begin
        pend_d = pend_q;
        addr_d = addr_q;
        if (flush_i || adv_i) begin
            pend_d = 1'b0;
        end else if (branch_i) begin
            pend_d = 1'b1;
            addr_d = target_i;
        end
    end

    // Pending flag and target register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q <= 1'b0;
            addr_q <= '0;
        end else begin
            pend_q <= pend_d;
            addr_q <= addr_d;
        end
    end

    assign pend_o      = pend_q;
    assign pend_addr_o = addr_q;

endmodule

// File: rtl/pc_fetch_gen.sv
// IF-stage PC generator: fetch request enable, next-PC selection and misalign flag.
// Handshake: ce is request-valid, imem_gnt_i is the accept; a request is consumed on a
// cycle where ce=1, imem_gnt_i=1 and stall[0]=0, and only then does the PC step.
module pc_fetch_gen
    import pc_fetch_gen_pkg::*;
#(
    parameter int unsigned       ADDR_W       = ADDR_W_DEF,
    parameter logic [ADDR_W-1:0] RESET_VECTOR = ADDR_W'(RESET_VECTOR_DEF),
    parameter int unsigned       INST_BYTES   = 4,
    parameter int unsigned       FETCH_W      = 1,
    parameter int unsigned       STALL_W      = 6
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STALL_W-1:0] stall,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  new_pc,
    input  logic               branch_flag_i,
    input  logic [ADDR_W-1:0]  branch_target_address_i,
    input  logic               imem_gnt_i,
    output logic               ce,
    output logic [ADDR_W-1:0]  pc,
    output logic               redir_pend_o,
    output logic               misalign_o
);

    localparam logic [ADDR_W-1:0] STEP = ADDR_W'(FETCH_W * INST_BYTES);

    logic              ce_q;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              mis_q, mis_d;
    logic              adv;
    logic              flush_en;
    logic              branch_en;
    logic              pend;
    logic [ADDR_W-1:0] pend_addr;
    pc_sel_e           sel;
    logic              unused_stall;

    // Only stall[0] matters to fetch; the rest of the ctrl vector is for later stages.
    assign unused_stall = ^stall;

    // Redirect inputs are ignored in the single cycle after reset so the first request
    // is always for RESET_VECTOR.
    assign adv       = ce_q && (stall[0] != STOP) && imem_gnt_i;
    assign flush_en  = ce_q && flush;
    assign branch_en = ce_q && (branch_flag_i == BRANCH);

    pc_fetch_gen_redirect_hold #(
        .ADDR_W (ADDR_W)
    ) u_redirect_hold (
        .clk_i       (clk),
        .rst_ni      (rst),
        .flush_i     (flush_en),
        .adv_i       (adv),
        .branch_i    (branch_en),
        .target_i    (branch_target_address_i),
        .pend_o      (pend),
        .pend_addr_o (pend_addr)
    );

    // Pick the next-PC source: flush, live branch, held branch, sequential step, hold.
    always_comb begin
        sel = SEL_HOLD;
        if (flush_en) begin
            sel = SEL_FLUSH;
        end else if (adv && branch_en) begin
            sel = SEL_BRANCH;
        end else if (adv && pend) begin
            sel = SEL_PEND;
        end else if (adv) begin
            sel = SEL_STEP;
        end
    end

    // Form the next PC; only redirect targets are checked for alignment.
    always_comb begin
        pc_d  = pc_q;
        mis_d = 1'b0;
        case (sel)
            SEL_FLUSH:  pc_d = new_pc;
            SEL_BRANCH: pc_d = branch_target_address_i;
            SEL_PEND:   pc_d = pend_addr;
            SEL_STEP:   pc_d = pc_q + STEP;
            default:    pc_d = pc_q;
        endcase
        if (sel == SEL_FLUSH || sel == SEL_BRANCH || sel == SEL_PEND) begin
            mis_d = addr_misaligned(64'(pc_d), INST_BYTES);
        end
    end

    // Fetch enable rises on the first edge after reset and stays high.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ce_q <= CHIP_DISABLE;
        end else begin
            ce_q <= CHIP_ENABLE;
        end
    end

    // PC and misalign pulse registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc_q  <= RESET_VECTOR;
            mis_q <= 1'b0;
        end else begin
            pc_q  <= pc_d;
            mis_q <= mis_d;
        end
    end

    assign ce           = ce_q;
    assign pc           = pc_q;
    assign redir_pend_o = pend;
    assign misalign_o   = mis_q;

endmodule
